stereo_disparity: RTL and testbench

- Consumer of the rectified stereo pixel stream: per-pixel coordinates plus one left-image (a) and one right-image (b) 8-bit sample per clock, in the 640x480 active / 525-line timing used throughout the design.
- Computes a horizontal 1-row SAD block match over disparities 0..MAXD-1 and emits the winning disparity per pixel, aligned with delayed coordinates.
- Sits directly downstream of the rectifier and feeds display/depth logic.

---
 rtl/stereo_disparity.sv | 182 ++++++++++++++++++
 tb/tb_stereo_disparity.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/stereo_disparity.sv
// Stereo disparity estimator: one-row SAD block match over MAXD candidate disparities.
// Optional minimum-cost rejection is enabled with `define STEREO_COST_THRESH_EN.
module stereo_disparity #(
    parameter int MAXD     = 16,
    parameter int WIN      = 5,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int COST_MAX = 200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ix,
    input  logic [31:0] iy,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [31:0] ox,
    output logic [31:0] oy,
    output logic [7:0]  od,
    output logic        ovalid
);

    localparam int BLEN      = WIN + MAXD - 1;
    localparam int VALID_COL = WIN + MAXD - 2;
    localparam int COL_W     = $clog2(BLEN + 1);
    localparam int CW        = 8 + $clog2(WIN);
    localparam int DW        = $clog2(MAXD);

    function automatic logic [7:0] abs_diff(input logic [7:0] p, input logic [7:0] q);
        return (p > q) ? (p - q) : (q - p);
    endfunction

    // ---------------- S1: delay lines, column tracking, absolute differences
    logic [7:0]       a_line  [WIN];
    logic [7:0]       b_line  [BLEN];
    logic [7:0]       a_nx    [WIN];
    logic [7:0]       b_nx    [BLEN];
    logic [7:0]       diff    [MAXD][WIN];
    logic [7:0]       diff_nx [MAXD][WIN];
    logic [COL_W-1:0] col;
    logic [COL_W-1:0] col_nx;
    logic             synced;
    logic             synced_nx;
    logic             active;
    logic             v1_nx;
    logic             v1;
    logic [31:0]      x1;
    logic [31:0]      y1;

    assign active = (ix < 32'(H_ACTIVE)) && (iy < 32'(V_ACTIVE));

    always_comb begin
        for (int k = 0; k < WIN; k++) a_nx[k] = a_line[k];
        for (int k = 0; k < BLEN; k++) b_nx[k] = b_line[k];
        col_nx    = col;
        synced_nx = synced;
        if (active) begin
            a_nx[0] = a;
            for (int k = 1; k < WIN; k++) a_nx[k] = a_line[k-1];
            b_nx[0] = b;
            for (int k = 1; k < BLEN; k++) b_nx[k] = b_line[k-1];
            if (ix == 32'd0) begin
                col_nx    = '0;
                synced_nx = 1'b1;
            end else if (col != COL_W'(BLEN)) begin
                col_nx = col + COL_W'(1);
            end
        end
        // synced blocks a false window after reset until a line start is seen.
        v1_nx = active && synced_nx && (col_nx >= COL_W'(VALID_COL));
    end

    always_comb begin
        for (int d = 0; d < MAXD; d++) begin
            for (int k = 0; k < WIN; k++) begin
                diff_nx[d][k] = abs_diff(a_nx[k], b_nx[k+d]);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < WIN; k++) a_line[k] <= '0;
            for (int k = 0; k < BLEN; k++) b_line[k] <= '0;
            for (int d = 0; d < MAXD; d++) begin
                for (int k = 0; k < WIN; k++) diff[d][k] <= '0;
            end
            col    <= '0;
            synced <= 1'b0;
            v1     <= 1'b0;
            x1     <= '0;
            y1     <= '0;
        end else begin
            for (int k = 0; k < WIN; k++) a_line[k] <= a_nx[k];
            for (int k = 0; k < BLEN; k++) b_line[k] <= b_nx[k];
            for (int d = 0; d < MAXD; d++) begin
                for (int k = 0; k < WIN; k++) diff[d][k] <= diff_nx[d][k];
            end
            col    <= col_nx;
            synced <= synced_nx;
            v1     <= v1_nx;
            x1     <= ix;
            y1     <= iy;
        end
    end

    // ---------------- S2: window sums
    logic [CW-1:0] cost    [MAXD];
    logic [CW-1:0] cost_nx [MAXD];
    logic          v2;
    logic [31:0]   x2;
    logic [31:0]   y2;

    always_comb begin
        for (int d = 0; d < MAXD; d++) begin
            cost_nx[d] = '0;
            for (int k = 0; k < WIN; k++) begin
                cost_nx[d] = cost_nx[d] + CW'(diff[d][k]);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int d = 0; d < MAXD; d++) cost[d] <= '0;
            v2 <= 1'b0;
            x2 <= '0;
            y2 <= '0;
        end else begin
            for (int d = 0; d < MAXD; d++) cost[d] <= cost_nx[d];
            v2 <= v1;
            x2 <= x1;
            y2 <= y1;
        end
    end

    // ---------------- S3: argmin, strict compare keeps the smallest d on ties
    logic [CW-1:0] best_c;
    logic [DW-1:0] best_d;
    logic          ovalid_nx;
    logic [7:0]    od_nx;

    always_comb begin
        best_c = cost[0];
        best_d = '0;
        for (int d = 1; d < MAXD; d++) begin
            if (cost[d] < best_c) begin
                best_c = cost[d];
                best_d = DW'(d);
            end
        end
`ifdef STEREO_COST_THRESH_EN
        ovalid_nx = v2 && (32'(best_c) <= 32'(COST_MAX));
`else
        ovalid_nx = v2;
`endif
        od_nx = ovalid_nx ? 8'(best_d) : 8'd0;
    end

`ifdef STEREO_COST_THRESH_EN
    logic [CW-1:0] min_cost;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) min_cost <= '0;
        else     min_cost <= best_c;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ox     <= '0;
            oy     <= '0;
            od     <= '0;
            ovalid <= 1'b0;
        end else begin
            ox     <= x2;
            oy     <= y2;
            od     <= od_nx;
            ovalid <= ovalid_nx;
        end
    end

endmodule

// File: tb/tb_stereo_disparity.sv
// Directed bench for stereo_disparity: flat, ramp, blanking, reset, tie-break and cost-threshold lines.
module tb_stereo_disparity;

    logic        clk;
    logic        rst;
    logic [31:0] ix;
    logic [31:0] iy;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [31:0] ox;
    logic [31:0] oy;
    logic [7:0]  od;
    logic        ovalid;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_x_q  [$];
    logic [31:0] exp_y_q  [$];
    logic        exp_v_q  [$];
    logic [7:0]  exp_od_q [$];
    logic        chk_q    [$];

    stereo_disparity dut (
        .clk    (clk),
        .rst    (rst),
        .ix     (ix),
        .iy     (iy),
        .a      (a),
        .b      (b),
        .ox     (ox),
        .oy     (oy),
        .od     (od),
        .ovalid (ovalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] ramp(input int x);
        return 8'((x * 3) % 192);
    endfunction

    // True when every a/b value a ramp window at column x touches lies in one linear segment.
    function automatic logic ramp_clean(input int x);
        return ((x - 14) / 64) == ((x + 5) / 64);
    endfunction

    function automatic logic [7:0] tie_a(input int x);
        case (x)
            26: return 8'd170;
            27: return 8'd130;
            28: return 8'd90;
            29: return 8'd50;
            30: return 8'd10;
            default: return 8'd0;
        endcase
    endfunction

    function automatic logic [7:0] tie_b(input int x);
        case (x)
            28, 23: return 8'd10;
            27, 22: return 8'd50;
            26, 21: return 8'd90;
            25, 20: return 8'd130;
            24, 19: return 8'd170;
            default: return 8'd255;
        endcase
    endfunction

    task automatic check_out(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic step(input int x, input int y, input logic [7:0] av, input logic [7:0] bv,
                        input logic ev, input logic [7:0] eod, input logic chk_od);
        ix = 32'(x);
        iy = 32'(y);
        a  = av;
        b  = bv;
        exp_x_q.push_back(32'(x));
        exp_y_q.push_back(32'(y));
        exp_v_q.push_back(ev);
        exp_od_q.push_back(ev ? eod : 8'd0);
        chk_q.push_back(chk_od || !ev);
        @(posedge clk);
        #1;
        if (exp_x_q.size() == 3) begin
            logic [31:0] ex;
            logic [31:0] ey;
            logic        evv;
            logic [7:0]  eo;
            logic        ck;
            ex  = exp_x_q.pop_front();
            ey  = exp_y_q.pop_front();
            evv = exp_v_q.pop_front();
            eo  = exp_od_q.pop_front();
            ck  = chk_q.pop_front();
            check_out("ox", ox, ex);
            check_out("oy", oy, ey);
            check_out("ovalid", 32'(ovalid), 32'(evv));
            if (ck) check_out("od", 32'(od), 32'(eo));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_out({tag, "_ox"}, ox, 32'd0);
        check_out({tag, "_oy"}, oy, 32'd0);
        check_out({tag, "_od"}, 32'(od), 32'd0);
        check_out({tag, "_ovalid"}, 32'(ovalid), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        ix  = '0;
        iy  = '0;
        a   = '0;
        b   = '0;
        #1;
        check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Line 0: flat image, all costs tie at 0.
        for (int x = 0; x < 640; x++) step(x, 0, 8'd100, 8'd100, x >= 19, 8'd0, 1'b1);
        for (int x = 640; x < 800; x++) step(x, 0, 8'd100, 8'd100, 1'b0, 8'd0, 1'b1);

        // Line 1: ramp with b shifted by 5, then blanking.
        for (int x = 0; x < 640; x++)
            step(x, 1, ramp(x), ramp(x + 5), x >= 19, 8'd5, ramp_clean(x));
        for (int x = 640; x < 800; x++)
            step(x, 1, 8'(x), 8'(x * 7), 1'b0, 8'd0, 1'b1);

        // Line 2: column counter restarts after blanking.
        for (int x = 0; x <= 30; x++)
            step(x, 2, ramp(x), ramp(x + 5), x >= 19, 8'd5, 1'b1);

        // Line 3: reset pulse at ix = 300, released mid-line.
        for (int x = 0; x < 300; x++) step(x, 3, 8'd100, 8'd100, x >= 19, 8'd0, 1'b1);
        ix = 32'd300;
        iy = 32'd3;
        rst = 1'b1;
        #1;
        check_reset_outputs("midline_reset");
        exp_x_q.delete();
        exp_y_q.delete();
        exp_v_q.delete();
        exp_od_q.delete();
        chk_q.delete();
        @(posedge clk);
        #1;
        check_reset_outputs("reset_held");
        rst = 1'b0;
        for (int x = 301; x <= 350; x++) step(x, 3, 8'd100, 8'd100, 1'b0, 8'd0, 1'b1);

        // Line 4: first valid output after reset needs a fresh line start.
        for (int x = 0; x <= 25; x++) step(x, 4, 8'd100, 8'd100, x >= 19, 8'd0, 1'b1);

        // Line 5: C[2] = C[7] = 0 at ox = 30, all other costs positive.
        for (int x = 0; x <= 30; x++)
            step(x, 5, tie_a(x), tie_b(x), x >= 19, 8'd2, x == 30);

        // Line 6: uncorrelated data, every cost well above COST_MAX.
        for (int x = 0; x <= 40; x++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            ra = 8'($urandom_range(0, 40));
            rb = 8'($urandom_range(200, 255));
`ifdef STEREO_COST_THRESH_EN
            step(x, 6, ra, rb, 1'b0, 8'd0, 1'b1);
`else
            step(x, 6, ra, rb, x >= 19, 8'd0, 1'b0);
`endif
        end

        // Drain the pipeline with blanking samples.
        step(800, 6, 8'd0, 8'd0, 1'b0, 8'd0, 1'b1);
        step(801, 6, 8'd0, 8'd0, 1'b0, 8'd0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
